// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache with 4-word (128-bit) lines.
// A hit returns the word combinationally. A miss stalls IF, refills the whole
// block from instruction memory, and the held fetch then completes as a hit.
// Optional feature macro: ICACHE_STATS_EN adds saturating hit/miss counters.
//
//   state    | meaning
//   S_IDLE   | serving hits; a miss starts a refill
//   S_REFILL | block request outstanding, waiting for mem_ready
module icache_dm #(
  parameter int LINES = 8,
  parameter int IDX_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          I_read,
  input  logic [29:0]   I_addr,
  output logic          I_stall,
  output logic [31:0]   I_rdata,
  output logic          mem_read,
  output logic [27:0]   mem_addr,
  input  logic          mem_ready,
  input  logic [127:0]  mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];
  logic [27:0]        refill_addr_q;

  logic [1:0]         offset;
  logic [IDX_W-1:0]   index;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               start_refill;
  logic               fill;
  logic [IDX_W-1:0]   refill_index;
  logic [TAG_W-1:0]   refill_tag;

  assign offset       = I_addr[1:0];
  assign index        = I_addr[IDX_W+1:2];
  assign tag          = I_addr[29:IDX_W+2];
  assign hit          = valid_q[index] && (tag_q[index] == tag);
  assign refill_index = refill_addr_q[IDX_W-1:0];
  assign refill_tag   = refill_addr_q[27:IDX_W];

  // Memory always sees the latched block address, so a stray I_addr change
  // during a refill cannot corrupt the request.
  assign mem_addr = refill_addr_q;

  // Word select from the indexed line; meaningful only on a hit.
  assign I_rdata = data_q[index][{offset, 5'd0} +: 32];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    I_stall      = 1'b0;
    mem_read     = 1'b0;
    start_refill = 1'b0;
    fill         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_read && !hit) begin
          I_stall      = 1'b1;
          start_refill = 1'b1;
          state_d      = S_REFILL;
        end
      end
      S_REFILL: begin
        I_stall  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid bits and refill address; reset invalidates every line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      refill_addr_q <= '0;
    end else begin
      if (start_refill) refill_addr_q <= I_addr[29:2];
      if (fill)         valid_q[refill_index] <= 1'b1;
    end
  end

  // Tag and data arrays are qualified by valid, so they are not reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[refill_index]  <= refill_tag;
      data_q[refill_index] <= mem_rdata;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == S_IDLE && I_read && hit && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (start_refill && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed plus randomized fetch sequences for icache_dm, checked
// against a line-level reference model (which block each line holds) and a
// memory whose contents are a pure function of block address.
module tb_icache_dm;

  localparam int LINES = 8;
  localparam int IDX_W = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          I_read;
  logic [29:0]   I_addr;
  logic          I_stall;
  logic [31:0]   I_rdata;
  logic          mem_read;
  logic [27:0]   mem_addr;
  logic          mem_ready;
  logic [127:0]  mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  icache_dm #(.LINES(LINES), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .I_read    (I_read),
    .I_addr    (I_addr),
    .I_stall   (I_stall),
    .I_rdata   (I_rdata),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: which block each line holds, plus expected counters.
  bit          line_ok  [LINES];
  logic [27:0] line_blk [LINES];
  int          m_hits;
  int          m_miss;
  logic [31:0] seed;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
    logic [31:0] b;
    logic [31:0] ww;
    b  = {4'b0, blk};
    ww = {30'b0, w};
    return (b * 32'h9E37_79B1) ^ (ww * 32'h7F4A_7C15) ^ seed;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  function automatic logic [29:0] rand_addr();
    logic [24:0] t;
    logic [2:0]  i;
    logic [1:0]  o;
    case ($urandom_range(0, 3))
      0:       t = 25'h0;
      1:       t = 25'h1;
      2:       t = 25'h100_0000;
      default: t = 25'h100_0001;
    endcase
    i = 3'($urandom_range(0, 7));
    o = 2'($urandom_range(0, 3));
    return {t, i, o};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) line_ok[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_miss);
`endif
  endtask

  // One fetch held until it completes; lat is the memory latency N (ready at refill cycle N).
  task automatic fetch(input logic [29:0] a, input int lat);
    logic [27:0] blk;
    int          idx;
    bit          hit;
    blk = a[29:2];
    idx = int'(blk % LINES);
    hit = line_ok[idx] && (line_blk[idx] == blk);
    @(negedge clk);
    I_read    = 1'b1;
    I_addr    = a;
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("stall_first", I_stall, !hit);
    chk("mem_read_first", mem_read, 1'b0);
    if (hit) begin
      chk("rdata_hit", I_rdata, mem_word(blk, a[1:0]));
      m_hits++;
    end else begin
      m_miss++;
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        mem_ready = (k == lat);
        mem_rdata = (k == lat) ? mem_block(blk) : {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("stall_refill", I_stall, 1'b1);
        chk("mem_read_refill", mem_read, 1'b1);
        chk("mem_addr_refill", mem_addr, blk);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("stall_after_fill", I_stall, 1'b0);
      chk("mem_read_after_fill", mem_read, 1'b0);
      chk("rdata_after_fill", I_rdata, mem_word(blk, a[1:0]));
      line_ok[idx]  = 1'b1;
      line_blk[idx] = blk;
      m_hits++;
    end
    @(posedge clk);
    #1;
    check_stats();
  endtask

  // I_read low with an arbitrary address; stray mem_ready pulses must be ignored.
  task automatic idle_cycles(input int n, input logic [29:0] a);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      I_read    = 1'b0;
      I_addr    = a;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("idle_stall", I_stall, 1'b0);
      chk("idle_mem_read", mem_read, 1'b0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_stats();
  endtask

  initial begin
    seed      = $urandom;
    rst       = 1'b1;
    I_read    = 1'b0;
    I_addr    = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();

    // Reset state: everything invalid, so a request stalls; no memory request.
    @(negedge clk);
    I_read = 1'b1;
    I_addr = 30'h4;
    #1;
    chk("rst_stall", I_stall, 1'b1);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_addr", mem_addr, 28'h0);
    check_stats();
    @(negedge clk);
    rst    = 1'b0;
    I_read = 1'b0;

    // Cold miss with latency 3, then line sweep hits.
    fetch(30'h4, 3);
    for (int w = 4; w < 8; w++) fetch(30'(w), 1);

    // Conflict eviction on index 1, refetch of the evicted block misses again.
    fetch(30'h24, 2);
    fetch(30'h4, 2);
    fetch(30'h27, 2);

    // Fast memory: ready in the first refill cycle.
    fetch(30'h3A, 1);
    fetch(30'h38, 1);

    // I_read low for 5 cycles with an uncached address.
    idle_cycles(5, 30'h0ABC_DE50);
    fetch(30'h0ABC_DE50, 2);

    // Reset in the middle of a refill; a late mem_ready must not fill the line.
    @(negedge clk);
    I_read = 1'b1;
    I_addr = 30'h0000_0150;
    #1;
    chk("mid_first_stall", I_stall, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("mid_mem_read", mem_read, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_read", mem_read, 1'b0);
    chk("mid_rst_mem_addr", mem_addr, 28'h0);
    chk("mid_rst_stall", I_stall, 1'b1);
    model_reset();
    check_stats();
    @(negedge clk);
    I_read = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = mem_block(28'h54);
    #1;
    chk("late_ready_mem_read", mem_read, 1'b0);
    chk("late_ready_stall", I_stall, 1'b0);
    fetch(30'h0000_0150, 2);
    fetch(30'h4, 1);

    // Randomized mix of fetches and idle gaps.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) idle_cycles($urandom_range(1, 3), rand_addr());
      else                           fetch(rand_addr(), $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the IF stage's I-port (`I_read`, `I_addr`, `I_stall`, `I_rdata`) and the instruction memory.
- A hit returns the word combinationally in the same cycle.
- A miss raises `I_stall` and fetches the full 4-word block from memory through a request/ready handshake.
- After the refill, the stalled fetch completes as a hit.

## Interface
- `LINES`, default 8: number of cache lines; power of two, minimum 2.
- `IDX_W`, default 3: log2(`LINES`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `I_read` input 1: fetch request from IF; the IF stage holds it at 1 continuously.
- `I_addr` input 30: word address.
  - offset = `I_addr[1:0]`
  - index = `I_addr[IDX_W+1:2]`
  - tag = `I_addr[29:IDX_W+2]`
- `I_stall` output 1: 1 while the requested word is not available.
- `I_rdata` output 32: the requested instruction word; valid when `I_read=1` and `I_stall=0`.
- `mem_read` output 1: block read request to memory.
- `mem_addr` output 28: block address, equal to `I_addr[29:2]`.
- `mem_ready` input 1: one-cycle pulse; `mem_rdata` is valid in that cycle.
- `mem_rdata` input 128: block data; word 0 is in `[31:0]`, word 3 is in `[127:96]`.
- `hit_count` output 32: present only with `ICACHE_STATS_EN`.
- `miss_count` output 32: present only with `ICACHE_STATS_EN`.

## Operation
- Storage per line:
  - valid bit
  - tag, 28-`IDX_W` bits
  - 128-bit data
- hit = `valid[index]` & (`tag[index]` == `I_addr` tag).
- FSM has two states: `S_IDLE` and `S_REFILL`.
- **`S_IDLE`:**
  - `I_stall` = `I_read` & ~hit.
  - `I_rdata` = word `offset` of line `index`, combinational.
  - On `I_read` & ~hit, go to `S_REFILL` and latch `I_addr[29:2]` into the refill-address register.
  - `mem_read` = 0.
  - `mem_ready` is ignored in this state.
- **`S_REFILL`:**
  - `I_stall` = 1.
  - `mem_read` = 1.
  - `mem_addr` = latched block address.
  - Both are held until `mem_ready`.
  - On `mem_ready`: write `mem_rdata` into line (latched index), write the latched tag, set valid = 1, and return to `S_IDLE`.
- Refill data is not forwarded to `I_rdata`. The fetch completes the next cycle as a normal hit.
- The IF stage holds `I_addr` stable while `I_stall=1`. This includes a branch redirect while stalled: IF defers that redirect until `I_stall` falls. The cache uses only the latched refill address during `S_REFILL`.
- `I_read=0` in `S_IDLE`: `I_stall`=0 and no state change. `I_rdata` is don't-care.
- No write path, no invalidate port. Contents persist until reset.

## Timing
- Reset values:
  - state = `S_IDLE`
  - all valid bits = 0
  - `mem_read`=0
  - `mem_addr`=0, from the refill-address register
  - counters = 0
  - `I_stall` = `I_read` (every line is invalid)
  - `I_rdata` is don't-care, and data arrays are not reset.
- Hit latency: 0 cycles. Data and `I_stall`=0 appear in the same cycle as `I_addr`.
- Miss timing:
  - Cycle 0: `I_stall` rises combinationally.
  - Cycle 1: `mem_read`=1.
  - `mem_ready` arrives at cycle N (N≥1).
  - Cycle N+1: back in `S_IDLE` with a hit, `I_stall`=0.
  - Total stall = N+1 cycles.
- A `mem_ready` arriving in the first `S_REFILL` cycle is accepted. Penalty in that case is 2 cycles.
- Back-to-back misses to different lines: each incurs its own full refill, and the following fetch re-enters `S_REFILL` directly from `S_IDLE`.
- Conflict miss (same index, different tag): the line is overwritten and the old block is lost.
- Reset asserted mid-refill:
  - state goes to `S_IDLE` and valids clear immediately (asynchronous).
  - `mem_read` drops in the same cycle.
  - A late `mem_ready` is ignored.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds `hit_count` and `miss_count`.
  - `hit_count` increments on each `S_IDLE` cycle with `I_read` & hit.
  - `miss_count` increments on each `S_IDLE`→`S_REFILL` transition.
  - Both saturate at 32'hFFFFFFFF.
  - Both reset to 0.
- `ICACHE_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Cold miss: after reset, `I_addr`=30'h0000_0004 with memory latency 3 cycles.
  - Required: `I_stall`=1 for 4 cycles, `mem_read`=1 with `mem_addr`=28'h1.
  - Then `I_rdata` = `mem_rdata[31:0]`, `I_stall`=0.
  - With stats: `miss_count`=1, `hit_count`=1.
- Line hits: after the refill above, sweep `I_addr` 30'h4–30'h7.
  - Required: each cycle `I_stall`=0 and the words are `mem_rdata[31:0]`, `[63:32]`, `[95:64]`, `[127:96]`.
  - `mem_read` stays 0.
- Conflict eviction (`LINES`=8): fill block 28'h01 (its line, index 1), then fetch 30'h24 (block 28'h09, same index 1).
  - Required: a miss with a refill.
  - Refetch of 30'h4 misses again.
- Fast memory: `mem_ready` in the first `S_REFILL` cycle.
  - Required: 2-cycle stall, correct data.
- Reset mid-refill: assert `rst` while `mem_read`=1, then release it and fetch the same address.
  - Required: `mem_read` falls immediately and a late `mem_ready` is ignored.
  - The fetch misses again.
- `I_read`=0 for 5 cycles in `S_IDLE` with an uncached address.
  - Required: `I_stall`=0 and `mem_read`=0 throughout.
  - Counters unchanged.
